// File: rtl/axibram_wr_arbiter_pkg.sv
// Shared types for the two-requester BRAM write arbiter: FSM encoding, requester ids, counter sizing.
// Pure declarations; no timing or flow-control behaviour of its own.
package axibram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OWN_A = 3'd1,
        ST_OWN_B = 3'd2,
        ST_SW_A  = 3'd3,
        ST_SW_B  = 3'd4
    } arb_state_t;

    localparam logic ARB_A = 1'b0;
    localparam logic ARB_B = 1'b1;

    // Quantum counter only ever needs to hold 0..QUANTUM-1.
    function automatic int qcnt_width(input int quantum);
        return (quantum <= 2) ? 1 : $clog2(quantum);
    endfunction

endpackage

// File: rtl/axibram_wr_arbiter_if.sv
// Bundle of both requester write channels, their grants/errors and the shared BRAM write port.
// master = requester/command side, slave = arbiter.
interface axibram_wr_arbiter_if #(
    parameter int ADDRESS_BITS = 10
);
    logic                    req_a;
    logic                    req_b;
    logic                    ready_a;
    logic                    ready_b;
    logic                    wen_a;
    logic                    wen_b;
    logic [ADDRESS_BITS-1:0] waddr_a;
    logic [ADDRESS_BITS-1:0] waddr_b;
    logic [3:0]              wstb_a;
    logic [3:0]              wstb_b;
    logic [31:0]             wdata_a;
    logic [31:0]             wdata_b;
    logic [ADDRESS_BITS-1:0] bram_waddr;
    logic                    bram_wen;
    logic [3:0]              bram_wstb;
    logic [31:0]             bram_wdata;
    logic                    err_a;
    logic                    err_b;
    logic                    clr_err;

    modport slave (
        input  req_a, req_b, wen_a, wen_b, waddr_a, waddr_b,
               wstb_a, wstb_b, wdata_a, wdata_b, clr_err,
        output ready_a, ready_b, bram_waddr, bram_wen, bram_wstb,
               bram_wdata, err_a, err_b
    );

    modport master (
        output req_a, req_b, wen_a, wen_b, waddr_a, waddr_b,
               wstb_a, wstb_b, wdata_a, wdata_b, clr_err,
        input  ready_a, ready_b, bram_waddr, bram_wen, bram_wstb,
               bram_wdata, err_a, err_b
    );

endinterface

// File: rtl/axibram_wr_arbiter_port_reg.sv
// Registered 2:1 BRAM write-port mux; the selected side's write appears on the port one cycle later.
// No backpressure: the unselected side's strobe is simply gated off here.
module axibram_wr_port_reg
    import axibram_arb_pkg::*;
#(
    parameter int ADDRESS_BITS = 10
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    sel,
    input  logic                    wen_a,
    input  logic                    wen_b,
    input  logic [ADDRESS_BITS-1:0] waddr_a,
    input  logic [ADDRESS_BITS-1:0] waddr_b,
    input  logic [3:0]              wstb_a,
    input  logic [3:0]              wstb_b,
    input  logic [31:0]             wdata_a,
    input  logic [31:0]             wdata_b,
    output logic [ADDRESS_BITS-1:0] bram_waddr,
    output logic                    bram_wen,
    output logic [3:0]              bram_wstb,
    output logic [31:0]             bram_wdata
);

    logic wen_sel;
    assign wen_sel = (sel == ARB_A) ? wen_a : wen_b;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bram_wen   <= 1'b0;
            bram_waddr <= '0;
            bram_wstb  <= '0;
            bram_wdata <= '0;
        end else begin
            bram_wen <= wen_sel;
            if (wen_sel) begin
                bram_waddr <= (sel == ARB_A) ? waddr_a : waddr_b;
                bram_wstb  <= (sel == ARB_A) ? wstb_a  : wstb_b;
                bram_wdata <= (sel == ARB_A) ? wdata_a : wdata_b;
            end
        end
    end

endmodule

// File: rtl/axibram_wr_arbiter.sv
// Round-robin arbiter of one BRAM write port between two requesters, QUANTUM writes per turn.
// Grant = registered ready; write reaches port 1 cycle after wen; one handover cycle covers ready lag.
module axibram_wr_arbiter
    import axibram_arb_pkg::*;
#(
    parameter int ADDRESS_BITS = 10,
    parameter int QUANTUM      = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axibram_wr_arbiter_if.slave   bus
);

    localparam int              QW   = qcnt_width(QUANTUM);
    localparam logic [QW-1:0]   QMAX = QW'(QUANTUM - 1);

    arb_state_t      state;
    arb_state_t      nxt;
    logic            sel;
    logic [QW-1:0]   qcnt;
    logic            ready_a_q;
    logic            ready_b_q;
    logic            err_a_q;
    logic            err_b_q;
    logic            wen_sel;

    assign wen_sel = (sel == ARB_A) ? bus.wen_a : bus.wen_b;

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  nxt = bus.req_a ? ST_OWN_A : (bus.req_b ? ST_OWN_B : ST_IDLE);
            ST_OWN_A: if (bus.req_b && (!bus.req_a || (qcnt == QMAX && bus.wen_a))) nxt = ST_SW_B;
            ST_OWN_B: if (bus.req_a && (!bus.req_b || (qcnt == QMAX && bus.wen_b))) nxt = ST_SW_A;
            ST_SW_A:  nxt = ST_OWN_A;
            ST_SW_B:  nxt = ST_OWN_B;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            sel       <= ARB_A;
            qcnt      <= '0;
            ready_a_q <= 1'b0;
            ready_b_q <= 1'b0;
            err_a_q   <= 1'b0;
            err_b_q   <= 1'b0;
        end else begin
            state     <= nxt;
            ready_a_q <= (nxt == ST_OWN_A);
            ready_b_q <= (nxt == ST_OWN_B);

            // sel only moves on entry to ownership, so a lagged write during SW_* still lands.
            if (nxt == ST_OWN_A && state != ST_OWN_A) begin
                sel  <= ARB_A;
                qcnt <= '0;
            end else if (nxt == ST_OWN_B && state != ST_OWN_B) begin
                sel  <= ARB_B;
                qcnt <= '0;
            end else if (wen_sel && qcnt != QMAX) begin
                qcnt <= qcnt + 1'b1;
            end

            if (bus.wen_a && sel != ARB_A) err_a_q <= 1'b1;
            else if (bus.clr_err)          err_a_q <= 1'b0;
            if (bus.wen_b && sel != ARB_B) err_b_q <= 1'b1;
            else if (bus.clr_err)          err_b_q <= 1'b0;
        end
    end

    assign bus.ready_a = ready_a_q;
    assign bus.ready_b = ready_b_q;
    assign bus.err_a   = err_a_q;
    assign bus.err_b   = err_b_q;

    axibram_wr_port_reg #(
        .ADDRESS_BITS (ADDRESS_BITS)
    ) u_port (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .sel        (sel),
        .wen_a      (bus.wen_a),
        .wen_b      (bus.wen_b),
        .waddr_a    (bus.waddr_a),
        .waddr_b    (bus.waddr_b),
        .wstb_a     (bus.wstb_a),
        .wstb_b     (bus.wstb_b),
        .wdata_a    (bus.wdata_a),
        .wdata_b    (bus.wdata_b),
        .bram_waddr (bus.bram_waddr),
        .bram_wen   (bus.bram_wen),
        .bram_wstb  (bus.bram_wstb),
        .bram_wdata (bus.bram_wdata)
    );

endmodule

// File: doc/axibram_wr_arbiter.md
# axibram_wr_arbiter

Two-requester arbiter sharing one BRAM write port between two AXI-to-BRAM write bridges (e.g. GP0 and GP1 paths) or a bridge and a local command writer. Grants ownership through each requester's `dev_ready`-style ready input, round-robin with a write-count quantum. It absorbs the requester's one-cycle registered-ready lag with a handover cycle, and drives the shared port through a registered mux.

## Interface
- `ADDRESS_BITS`, 10: BRAM word address width.
- `QUANTUM`, 8: maximum writes per grant while the other side requests; legal range 2..256.
- `aclk` in 1: clock; all logic on rising edge.
- `aresetn` in 1: reset, asynchronous assert, active-low.
- `req_a` / `req_b` in 1: requester has pending writes. Held high while any granted write is outstanding.
- `ready_a` / `ready_b` out 1: grant, wired to the requester's `dev_ready`. Registered.
- `wen_a` / `wen_b` in 1: requester write strobe.
- `waddr_a` / `waddr_b` in ADDRESS_BITS: requester write address.
- `wstb_a` / `wstb_b` in 4: byte enables.
- `wdata_a` / `wdata_b` in 32: write data.
- `bram_waddr` out ADDRESS_BITS, `bram_wen` out 1, `bram_wstb` out 4, `bram_wdata` out 32: shared BRAM write port. All registered.
- `err_a` / `err_b` out 1: sticky. Set when that requester writes while not selected.
- `clr_err` in 1: synchronous clear of both error flags.

## Operation
- States:
  - IDLE: reset only.
  - OWN_A / OWN_B: grant held.
  - SW_A / SW_B: handover towards A / towards B.
- Transitions:
  - IDLE: goes to OWN_A if `req_a`, else to OWN_B if `req_b`.
  - OWN_x, leave condition: the other side requests AND (`req_x` low OR `qcnt` == QUANTUM-1 with `wen_x` this cycle).
  - OWN_x, when leaving: go to SW_y.
  - OWN_x, otherwise: stay. The grant parks on the last owner when the other side is idle.
  - SW_y: always goes to OWN_y after exactly 1 cycle.
- `ready_x` = registered (next state == OWN_x). Ready is low during SW_* and IDLE.
- `sel` register (mux select):
  - Updated only on entry to OWN_x.
  - Keeps the old owner through SW_*, so the requester's lagged last write is still passed.
- Accepted write: `wen_sel` high. Drives the port next cycle and increments `qcnt`.
- Write from the unselected side:
  - Dropped; never reaches the port.
  - Sets `err_x`. Set has priority over a simultaneous `clr_err`.
- `qcnt`: width clog2(QUANTUM). Cleared on every OWN_x entry. Saturates at QUANTUM-1.
- Round-robin: if both sides request in IDLE, A wins. Thereafter, priority is the non-last owner.
- Reset mid-burst: all state to IDLE immediately. The requester stalls because its ready is low.

## Timing
- Reset values:
  - `ready_a`/`ready_b` 0.
  - `bram_wen` 0; `bram_waddr`, `bram_wstb`, `bram_wdata` 0.
  - `err_a`/`err_b` 0.
  - `qcnt` 0, `sel` = A, state IDLE.
- Write latency: `wen_x` at cycle n gives `bram_wen` at n+1, with `bram_waddr`/`bram_wstb`/`bram_wdata` from cycle n.
- Grant latency: `req_x` rises at n with the port idle, so `ready_x` = 1 at n+1.
- Handover from A to B, with A's last counted write at cycle n:
  - `ready_a` falls at n+1.
  - SW_B covers n+1, and A's lagged write at n+1 is still accepted.
  - `ready_b` rises at n+2.
  - Minimum gap: 1 cycle with no ready.
- `bram_wen` is never driven by both sources in one cycle. At most one write per cycle.

## Structure
- Package `axibram_arb_pkg`:
  - State encoding constants.
  - Requester index constants (`ARB_A` = 0, `ARB_B` = 1).
  - Quantum counter width function.
- Sub-module `axibram_wr_port_reg`: registered 2:1 port mux with synchronous `wen` gating and async reset.
- FSM, counter and error logic stay in the top.

## Test plan
- Reset, then `req_a` only, with A writing addresses 0x000..0x00F (16 beats) → `ready_b` never 1. `bram_waddr` 0x000..0x00F, each one cycle after its `wen_a`. `err_*` = 0.
- `req_a` and `req_b` rise together, both streaming, QUANTUM=8:
  - A writes 8 beats, then 1 handover cycle, then B writes 8 beats, alternating.
  - No lost beats; the port write count equals the sum of the requester counts.
- Requester model with registered ready: issue a write in the cycle after `ready_a` falls → that write appears on the port. `err_a` = 0.
- `wen_b` pulsed while A is owner → no port write from B, `err_b` = 1. Then `clr_err` → `err_b` = 0. Simultaneous violation and `clr_err` → `err_b` stays 1.
- A owns, `req_a` drops after 3 writes, `req_b` high → SW_B for 1 cycle, then `ready_b` = 1. Later, `req_b` drops with A idle → grant parks on B (`ready_b` stays 1).
- `aresetn` asserted mid-grant with `wen_a` high → all outputs 0 asynchronously. After release, `req_b` only → B is granted at the first cycle after release plus 1.
